param_queue: RTL

Parametrised ready/valid FIFO and the successor to the single-entry normal queue in the SPI datapath. It supports any depth from 1 upward, an optional pipe mode that accepts a message while full if one leaves in the same cycle, and an almost-full flag for upstream flow control. It also has a synchronous flush for aborting SPI transactions. It sits between the SPI shift logic and the packet/adapter layers, one instance per direction.

---
 rtl/param_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/param_queue.sv
`default_nettype none
// ============================================================================
// Module   : param_queue
// Purpose  : Ready/valid FIFO of any depth with pipe mode, almost-full flag
//            and synchronous flush. Define PARAM_QUEUE_BYPASS_EN for a
//            zero-latency pass-through when the queue is empty.
// Revision : 1.0
// ============================================================================
module param_queue #(
    parameter int NBITS        = 8,
    parameter int NUM_ENTRIES  = 2,
    parameter int PIPE_MODE    = 0,
    parameter int AFULL_THRESH = NUM_ENTRIES - 1,
    localparam int CW          = $clog2(NUM_ENTRIES + 1),
    localparam int PW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic [NBITS-1:0] recv_msg_i,
    input  logic             recv_val_i,
    output logic             recv_rdy_o,
    output logic [NBITS-1:0] send_msg_o,
    output logic             send_val_o,
    input  logic             send_rdy_i,
    output logic [CW-1:0]    count_o,
    output logic             almost_full_o
);

    localparam logic [CW-1:0] FULL_COUNT  = CW'(NUM_ENTRIES);
    localparam logic [CW-1:0] AFULL_LEVEL = CW'(AFULL_THRESH);
    localparam logic [PW-1:0] LAST_PTR    = PW'(NUM_ENTRIES - 1);

    logic [NBITS-1:0] mem_q [NUM_ENTRIES];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             afull_q, afull_d;

    logic w_full;
    logic w_empty;
    logic w_recv_xfer;
    logic w_send_xfer;
    logic w_pass;
    logic w_enq;
    logic w_deq;

    assign w_full  = (count_q == FULL_COUNT);
    assign w_empty = (count_q == '0);

    generate
        if (PIPE_MODE != 0) begin : g_pipe
            // A departing head frees the slot the incoming message will take.
            assign recv_rdy_o = (!w_full || send_rdy_i) && !clear_i;
        end else begin : g_normal
            assign recv_rdy_o = !w_full && !clear_i;
        end
    endgenerate

`ifdef PARAM_QUEUE_BYPASS_EN
    assign send_val_o = w_empty ? (recv_val_i && !clear_i) : !clear_i;
    assign send_msg_o = w_empty ? recv_msg_i : mem_q[head_q];
`else
    assign send_val_o = !w_empty && !clear_i;
    assign send_msg_o = mem_q[head_q];
`endif

    assign w_recv_xfer = recv_val_i && recv_rdy_o;
    assign w_send_xfer = send_val_o && send_rdy_i;

`ifdef PARAM_QUEUE_BYPASS_EN
    // Both transfers while empty can only be the pass-through path.
    assign w_pass = w_empty && w_recv_xfer && w_send_xfer;
`else
    assign w_pass = 1'b0;
`endif

    assign w_enq = w_recv_xfer && !w_pass;
    assign w_deq = w_send_xfer && !w_pass;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_enq) begin
                tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
            end
            if (w_deq) begin
                head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
            end
            if (w_enq && !w_deq) begin
                count_d = count_q + 1'b1;
            end else if (!w_enq && w_deq) begin
                count_d = count_q - 1'b1;
            end
        end
        afull_d = (count_d >= AFULL_LEVEL);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            afull_q <= (AFULL_LEVEL == '0);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            afull_q <= afull_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            mem_q[tail_q] <= recv_msg_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i && !clear_i) begin
            assert (count_q <= FULL_COUNT);
            assert (!(w_deq && w_empty));
        end
    end

    assign count_o       = count_q;
    assign almost_full_o = afull_q;

endmodule
`default_nettype wire
